// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB register-bank master.
package apb_arb_pkg;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} apb_state_e;

  localparam int unsigned DefaultTimeout = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic [1:0] elig_i,
  input  logic       last_i,
  output logic       gnt_idx_o,
  output logic       gnt_vld_o
);

  always_comb begin
    gnt_vld_o = |elig_i;
    gnt_idx_o = 1'b0;
    if (&elig_i) begin
      gnt_idx_o = ~last_i;
    end else if (elig_i[1]) begin
      gnt_idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/apb_reg_arbiter.sv
// APB master sequencing two internal requesters onto the register bank, with
// round-robin arbitration, wait-state support and a bounded-wait abort.
module apb_reg_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_i,
  input  logic [1:0]          wr_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          done_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  input  logic                pready_i,
  input  logic [DATA_W-1:0]   prdata_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] TimeoutM1  = CntW'(TIMEOUT - 1);

  apb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]        done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic [1:0] elig;
  logic       arb_idx;
  logic       arb_vld;

  // A requester whose done is high this cycle still shows its old req; mask it.
  assign elig = req_i & ~done_q;

  rr_arb2 u_rr_arb2 (
    .elig_i    (elig),
    .last_i    (last_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    wcnt_d    = wcnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          gnt_d    = arb_idx;
          last_d   = arb_idx;
          pwrite_d = wr_i[arb_idx];
          paddr_d  = arb_idx ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
          pwdata_d = arb_idx ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
          psel_d   = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        wcnt_d    = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done_d    = gnt_q ? 2'b10 : 2'b01;
          rdata_d   = pwrite_q ? '0 : prdata_i;
          state_d   = StIdle;
        end else begin
          if (wcnt_q != TimeoutCnt) begin
            wcnt_d = wcnt_q + 1'b1;
          end
          // This sample is the TIMEOUT-th consecutive low pready.
          if (wcnt_q >= TimeoutM1) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            done_d    = gnt_q ? 2'b10 : 2'b01;
            err_d     = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      wcnt_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      wcnt_q    <= wcnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule
